// File: rtl/control_top.sv
// Datapath core: 256-word unified memory (instruction + data port), 4-entry
// register bank with two read ports, and a combinational 32-bit ALU.
module control_top (
  input  logic        clk,
  input  logic        rst_n,
  // unified memory
  input  logic [31:0] Read_PC,
  input  logic [31:0] R_W_Addr,
  input  logic [31:0] DataWrite,
  input  logic        Op2En,
  input  logic        Op2RW,
  input  logic        M_Clear,
  output logic [31:0] Instruction,
  output logic [31:0] DataRead,
  // register bank
  input  logic        opwrite,
  input  logic [1:0]  reg_write,
  input  logic [31:0] data,
  input  logic [1:0]  src_1,
  input  logic [1:0]  src_2,
  output logic [31:0] data_src_1,
  output logic [31:0] data_src_2,
  // ALU
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [3:0]  op,
  output logic [31:0] rd
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  logic [31:0] mem [256];
  logic [31:0] regs [4];

  logic [7:0] pc_index;
  logic [7:0] data_index;
  logic       mem_write;
  logic       mem_read;

  // Addresses wrap modulo 256; the upper bits are deliberately ignored.
  assign pc_index   = Read_PC[7:0];
  assign data_index = R_W_Addr[7:0];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{Read_PC[31:8], R_W_Addr[31:8]};

  assign mem_write = Op2En &  Op2RW;
  assign mem_read  = Op2En & ~Op2RW;

  // NOTE: an asynchronously reset array cannot map onto a RAM macro; it is
  // built from flops, which is what makes the instant clear-to-zero possible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (M_Clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_write) begin
      // NOTE: non-blocking so same-cycle reads see the old word until the edge.
      mem[data_index] <= DataWrite;
    end
  end

  assign Instruction = mem[pc_index];
  assign DataRead    = mem_read ? mem[data_index] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (opwrite) begin
      regs[reg_write] <= data;
    end
  end

  // No write-to-read bypass: reads show the registered value only.
  assign data_src_1 = regs[src_1];
  assign data_src_2 = regs[src_2];

  always_comb begin
    // NOTE: default first so every path assigns rd and no latch is inferred.
    rd = '0;
    case (op)
      ALU_AND: rd = rs & rt;
      ALU_OR:  rd = rs | rt;
      ALU_ADD: rd = rs + rt;
      ALU_SUB: rd = rs - rt;
      ALU_SLT: rd = {31'b0, $signed(rs) < $signed(rt)};
      ALU_NOR: rd = ~(rs | rt);
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_control_top.sv
// Scoreboard bench for control_top: expected values are queued when stimulus
// is driven and popped when the corresponding output is sampled.
module tb_control_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Read_PC, R_W_Addr, DataWrite;
  logic        Op2En, Op2RW, M_Clear;
  logic [31:0] Instruction, DataRead;
  logic        opwrite;
  logic [1:0]  reg_write, src_1, src_2;
  logic [31:0] data, data_src_1, data_src_2;
  logic [31:0] rs, rt, rd;
  logic [3:0]  op;

  always #5 clk = ~clk;

  control_top dut (
    .clk(clk), .rst_n(rst_n),
    .Read_PC(Read_PC), .R_W_Addr(R_W_Addr), .DataWrite(DataWrite),
    .Op2En(Op2En), .Op2RW(Op2RW), .M_Clear(M_Clear),
    .Instruction(Instruction), .DataRead(DataRead),
    .opwrite(opwrite), .reg_write(reg_write), .data(data),
    .src_1(src_1), .src_2(src_2),
    .data_src_1(data_src_1), .data_src_2(data_src_2),
    .rs(rs), .rt(rt), .op(op), .rd(rd)
  );

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic push_exp(input string name, input logic [31:0] value);
    exp_t x;
    x.name  = name;
    x.value = value;
    sb.push_back(x);
  endtask

  task automatic set_idle();
    Read_PC = '0; R_W_Addr = '0; DataWrite = '0;
    Op2En = 1'b0; Op2RW = 1'b0; M_Clear = 1'b0;
    opwrite = 1'b0; reg_write = '0; data = '0;
    src_1 = '0; src_2 = '0;
    rs = '0; rt = '0; op = '0;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] value);
    @(negedge clk);
    R_W_Addr = addr; DataWrite = value; Op2En = 1'b1; Op2RW = 1'b1;
    @(negedge clk);
    Op2En = 1'b0; Op2RW = 1'b0;
  endtask

  task automatic reg_wr(input logic [1:0] idx, input logic [31:0] value);
    @(negedge clk);
    opwrite = 1'b1; reg_write = idx; data = value;
    @(negedge clk);
    opwrite = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] addrs [2];
    addrs[0] = 32'd0;
    addrs[1] = 32'd255;
    mem_write(32'd0, 32'h1111_1111);
    mem_write(32'd255, 32'h2222_2222);
    for (int i = 0; i < 4; i++) reg_wr(2'(i), 32'hA0 + i);
    @(negedge clk);
    rst_n = 1'b0;
    // Sample while reset is still held: the clear must be asynchronous.
    for (int i = 0; i < 2; i++) begin
      push_exp("rst_data", 32'h0);
      push_exp("rst_instr", 32'h0);
      R_W_Addr = addrs[i]; Read_PC = addrs[i]; Op2En = 1'b1; Op2RW = 1'b0;
      #1;
      e = sb.pop_front(); vectors++;
      if (DataRead !== e.value) begin
        miscompares++;
        $display("FAIL %s addr=%0d: got %h expected %h", e.name, addrs[i], DataRead, e.value);
      end
      e = sb.pop_front(); vectors++;
      if (Instruction !== e.value) begin
        miscompares++;
        $display("FAIL %s addr=%0d: got %h expected %h", e.name, addrs[i], Instruction, e.value);
      end
    end
    for (int i = 0; i < 4; i++) begin
      push_exp("rst_reg", 32'h0);
      src_1 = 2'(i); src_2 = 2'(3 - i);
      #1;
      e = sb.pop_front(); vectors++;
      if (data_src_1 !== e.value || data_src_2 !== e.value) begin
        miscompares++;
        $display("FAIL %s R%0d: got %h/%h expected %h", e.name, i, data_src_1, data_src_2, e.value);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    set_idle();
  endtask

  task automatic test_memory();
    mem_write(32'd0, 32'h0000_0005);
    mem_write(32'd1, 32'h0000_000A);
    push_exp("mem_rd0", 32'h5);
    push_exp("mem_rd1", 32'hA);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      R_W_Addr = 32'(i); Op2En = 1'b1; Op2RW = 1'b0;
      #1;
      e = sb.pop_front(); vectors++;
      if (DataRead !== e.value) begin
        miscompares++;
        $display("FAIL %s: got %h expected %h", e.name, DataRead, e.value);
      end
    end
    // Port gated off, and write direction, both force DataRead to zero.
    push_exp("mem_gate_en", 32'h0);
    push_exp("mem_gate_rw", 32'h0);
    @(negedge clk);
    Op2En = 1'b0;
    #1;
    e = sb.pop_front(); vectors++;
    if (DataRead !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, DataRead, e.value);
    end
    Op2En = 1'b1; Op2RW = 1'b1; DataWrite = 32'h0000_000A;
    #1;
    e = sb.pop_front(); vectors++;
    if (DataRead !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, DataRead, e.value);
    end
    @(negedge clk);
    Op2En = 1'b0; Op2RW = 1'b0;
    push_exp("instr_pc1", 32'hA);
    Read_PC = 32'd1;
    #1;
    e = sb.pop_front(); vectors++;
    if (Instruction !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, Instruction, e.value);
    end
  endtask

  task automatic test_wrap();
    mem_write(32'h0000_0100, 32'hDEAD_BEEF);
    push_exp("wrap_data", 32'hDEAD_BEEF);
    push_exp("wrap_instr", 32'hDEAD_BEEF);
    @(negedge clk);
    R_W_Addr = 32'd0; Op2En = 1'b1; Op2RW = 1'b0; Read_PC = 32'hFFFF_FF00;
    #1;
    e = sb.pop_front(); vectors++;
    if (DataRead !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, DataRead, e.value);
    end
    e = sb.pop_front(); vectors++;
    if (Instruction !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, Instruction, e.value);
    end
    @(negedge clk);
    set_idle();
  endtask

  task automatic test_regs();
    reg_wr(2'd2, 32'h0000_1234);
    reg_wr(2'd3, 32'hFFFF_FFFF);
    push_exp("reg_src1", 32'h0000_1234);
    push_exp("reg_src2", 32'hFFFF_FFFF);
    @(negedge clk);
    src_1 = 2'd2; src_2 = 2'd3;
    #1;
    e = sb.pop_front(); vectors++;
    if (data_src_1 !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, data_src_1, e.value);
    end
    e = sb.pop_front(); vectors++;
    if (data_src_2 !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, data_src_2, e.value);
    end
    // Same-cycle write: old value before the edge, new value after.
    push_exp("reg_nobypass", 32'h0000_1234);
    push_exp("reg_after", 32'h0000_5678);
    push_exp("reg_other", 32'hFFFF_FFFF);
    opwrite = 1'b1; reg_write = 2'd2; data = 32'h0000_5678;
    #1;
    e = sb.pop_front(); vectors++;
    if (data_src_1 !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, data_src_1, e.value);
    end
    @(posedge clk);
    #1;
    opwrite = 1'b0;
    #1;
    e = sb.pop_front(); vectors++;
    if (data_src_1 !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, data_src_1, e.value);
    end
    e = sb.pop_front(); vectors++;
    if (data_src_2 !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, data_src_2, e.value);
    end
  endtask

  task automatic test_alu();
    logic [3:0]  ops  [10];
    logic [31:0] a    [10];
    logic [31:0] b    [10];
    logic [31:0] want [10];
    ops = '{4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111,
            4'b0000, 4'b0010, 4'b0111, 4'b0111};
    a   = '{32'd5, 32'd5, 32'd5, 32'd5, 32'd5, 32'd5,
            32'hF0F0_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    b   = '{32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA,
            32'h0FF0_00F0, 32'd1, 32'd1, 32'hFFFF_FFFF};
    want = '{32'hF, 32'hF, 32'hFFFF_FFFB, 32'd1, 32'hFFFF_FFF0, 32'd0,
             32'h00F0_00F0, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 10; i++) push_exp($sformatf("alu_op%b", ops[i]), want[i]);
    // rd must not depend on reset; hold reset low across one vector.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rs = a[i]; rt = b[i]; op = ops[i];
      rst_n = (i != 5);
      #1;
      e = sb.pop_front(); vectors++;
      if (rd !== e.value) begin
        miscompares++;
        $display("FAIL %s rs=%h rt=%h: got %h expected %h", e.name, rs, rt, rd, e.value);
      end
    end
    rst_n = 1'b1;
    set_idle();
    // The reset pulse above wiped the register bank; restore R3 for later.
    reg_wr(2'd3, 32'hFFFF_FFFF);
  endtask

  task automatic test_clear();
    logic [31:0] addrs [4];
    addrs = '{32'd3, 32'd0, 32'd200, 32'd255};
    mem_write(32'd3, 32'h0000_0033);
    mem_write(32'd200, 32'h0000_00C8);
    mem_write(32'd255, 32'h0000_00FF);
    @(negedge clk);
    M_Clear = 1'b1; R_W_Addr = 32'd3; DataWrite = 32'h0000_0077;
    Op2En = 1'b1; Op2RW = 1'b1;
    @(negedge clk);
    set_idle();
    for (int i = 0; i < 4; i++) begin
      push_exp("clr_data", 32'h0);
      push_exp("clr_instr", 32'h0);
      R_W_Addr = addrs[i]; Read_PC = addrs[i]; Op2En = 1'b1; Op2RW = 1'b0;
      #1;
      e = sb.pop_front(); vectors++;
      if (DataRead !== e.value) begin
        miscompares++;
        $display("FAIL %s addr=%0d: got %h expected %h", e.name, addrs[i], DataRead, e.value);
      end
      e = sb.pop_front(); vectors++;
      if (Instruction !== e.value) begin
        miscompares++;
        $display("FAIL %s addr=%0d: got %h expected %h", e.name, addrs[i], Instruction, e.value);
      end
    end
    push_exp("clr_regs_kept", 32'hFFFF_FFFF);
    src_1 = 2'd3;
    #1;
    e = sb.pop_front(); vectors++;
    if (data_src_1 !== e.value) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", e.name, data_src_1, e.value);
    end
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_memory();
    test_wrap();
    test_regs();
    test_alu();
    test_clear();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
